// File: rtl/adder_pkg.sv
// Shared defaults and stage-count derivation for the segmented pipelined adder.
package adder_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SEG_DEF   = 4;

  function automatic int stages_f(input int width, input int seg);
    return (width / seg < 1) ? 1 : width / seg;
  endfunction
endpackage

// File: rtl/adder_seg.sv
// SEG-bit combinational ripple segment; also exposes the carry into its MSB
// so the final segment can derive signed overflow.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o,
  output logic           cm_o
);

  always_comb begin
    logic c;
    s_o  = '0;
    cm_o = ci_i;
    c    = ci_i;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) cm_o = c;
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub, one SEG-bit slice per stage, valid/ready handshake on both
// sides; latency STAGES cycles, throughput one op per cycle.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = stages_f(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
  logic [STAGES-1:0]            vld_q, vld_d, c_q, c_d, ov_q, ov_d;
  logic [STAGES-1:0]            src_c, load, adv;
  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_co, seg_cm;

  // A stage may move whenever any later stage holds a bubble or the sink takes the result.
  always_comb begin
    logic hole;
    hole = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = vld_q[k] & hole;
      hole   = hole | ~vld_q[k];
    end
    in_ready = ~rst & hole;

    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub | cin;
    src_s[0] = '0;
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      load[k]  = adv[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_seg #(.SEG(SEG)) u_seg (
      .a_i  (src_a[k][k*SEG +: SEG]),
      .b_i  (src_b[k][k*SEG +: SEG]),
      .ci_i (src_c[k]),
      .s_o  (seg_s[k]),
      .co_o (seg_co[k]),
      .cm_o (seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k] & ~adv[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
      ov_d[k]  = ov_q[k];
      if (load[k]) begin
        vld_d[k]              = 1'b1;
        a_d[k]                = src_a[k];
        b_d[k]                = src_b[k];
        s_d[k]                = src_s[k];
        s_d[k][k*SEG +: SEG]  = seg_s[k];
        c_d[k]                = seg_co[k];
        ov_d[k]               = seg_co[k] ^ seg_cm[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ov_q  <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      ov_q  <= ov_d;
    end
  end

  assign q         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ov_q[LAST];
  assign out_valid = vld_q[LAST];

endmodule

// File: tb/tb_adder_pipe.sv
// Directed-vector bench for adder_pipe at WIDTH=16, SEG=4 (latency 4).
module tb_adder_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] a, b, q;
  logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  adder_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated op into an empty pipe: result must appear exactly on the 4th edge.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [15:0] eq, input logic ec, input logic eo);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_early_vld"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
  endtask

  initial begin
    int nacc;
    int nout;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_q", q, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Back-to-back adds
    a = 16'h0000; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pair_early_vld", out_valid, 1'b0);
    @(negedge clk);
    chk("pair0_vld", out_valid, 1'b1);
    chk("pair0_q", q, 16'h0001);
    chk("pair0_cout", cout, 1'b0);
    chk("pair0_ovf", ovf, 1'b0);
    @(negedge clk);
    chk("pair1_vld", out_valid, 1'b1);
    chk("pair1_q", q, 16'hFFFF);
    chk("pair1_cout", cout, 1'b1);
    chk("pair1_ovf", ovf, 1'b0);
    @(negedge clk);
    chk("pair_drain_vld", out_valid, 1'b0);

    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("borrow",  16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Back-pressure: sink stalls in cycles 5-9 while the source keeps pushing
    nacc = 0;
    nout = 0;
    for (int c = 1; c <= 40 && nout < 8; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (nacc < 8);
      a         = 16'(nacc + 1);
      b         = 16'(nacc + 1);
      cin       = 1'b0;
      sub       = 1'b0;
      #1;
      if (c >= 5 && c <= 9) begin
        chk("bp_full_in_ready", in_ready, 1'b0);
        chk("bp_hold_vld", out_valid, 1'b1);
        chk("bp_hold_q", q, 16'h0002);
        chk("bp_hold_cout", cout, 1'b0);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", q, 16'(2 * (nout + 1)));
        nout++;
      end
      if (in_valid && in_ready) nacc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", nout, 8);
    chk("bp_accepted", nacc, 8);
    @(negedge clk);
    chk("bp_drain_vld", out_valid, 1'b0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      a = 16'h1000; b = 16'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mid_rst_no_stale", out_valid, 1'b0);
      @(negedge clk);
    end
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
